// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns PCF, fetches over req/ack, loads the IF/ID register.
// Optional FETCH_PERF_EN macro adds FetchCount/BubbleCount performance counters.
module fetch_stage #(
  parameter int unsigned      XLEN      = 32,
  parameter logic [XLEN-1:0]  RESET_PC  = '0,
  parameter logic [31:0]      NOP_INSTR = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            StallD,
  input  logic            FlushD,
  input  logic            PCSrcE,
  input  logic [XLEN-1:0] PCTargetE,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [31:0]     imem_rdata,
  output logic [31:0]     InstrD,
  output logic [XLEN-1:0] PCD,
  output logic [XLEN-1:0] PCPlus4D,
`ifdef FETCH_PERF_EN
  output logic [31:0]     FetchCount,
  output logic [31:0]     BubbleCount,
`endif
  output logic            ValidD
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_DROP  = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] pcf_q, pcf_d;
  logic [XLEN-1:0] drop_addr_q, drop_addr_d;
  logic [31:0]     skid_q, skid_d;
  logic            deliver_c;
  logic [31:0]     deliver_instr_c;
  logic [XLEN-1:0] target_c;
  logic            unused_target_lsbs;

  // Redirect targets are word aligned; the low two bits are ignored.
  assign target_c           = {PCTargetE[XLEN-1:2], 2'b00};
  assign unused_target_lsbs = ^PCTargetE[1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_FETCH;
      pcf_q       <= RESET_PC;
      drop_addr_q <= '0;
      skid_q      <= '0;
    end else begin
      state_q     <= state_d;
      pcf_q       <= pcf_d;
      drop_addr_q <= drop_addr_d;
      skid_q      <= skid_d;
    end
  end

  // Next state, PC update and instruction delivery; redirect always wins over ack.
  always_comb begin
    state_d         = state_q;
    pcf_d           = pcf_q;
    drop_addr_d     = drop_addr_q;
    skid_d          = skid_q;
    deliver_c       = 1'b0;
    deliver_instr_c = skid_q;
    imem_req        = 1'b0;
    imem_addr       = pcf_q;
    case (state_q)
      S_FETCH: begin
        imem_req = 1'b1;
        if (PCSrcE) begin
          pcf_d = target_c;
          if (!imem_ack) begin
            state_d     = S_DROP;
            drop_addr_d = pcf_q;
          end
        end else if (imem_ack) begin
          if (StallD) begin
            skid_d  = imem_rdata;
            state_d = S_HOLD;
          end else begin
            deliver_c       = 1'b1;
            deliver_instr_c = imem_rdata;
          end
        end
      end
      S_DROP: begin
        imem_req  = 1'b1;
        imem_addr = drop_addr_q;
        if (PCSrcE) pcf_d = target_c;
        if (imem_ack) state_d = S_FETCH;
      end
      S_HOLD: begin
        if (PCSrcE) begin
          pcf_d   = target_c;
          state_d = S_FETCH;
        end else if (!StallD) begin
          deliver_c = 1'b1;
          state_d   = S_FETCH;
        end
      end
      default: state_d = S_FETCH;
    endcase
    if (deliver_c) pcf_d = pcf_q + XLEN'(4);
    if (rst) imem_req = 1'b0;
  end

  // IF/ID register: reset > flush (bubble) > stall (hold) > load or bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      InstrD   <= NOP_INSTR;
      PCD      <= '0;
      PCPlus4D <= '0;
      ValidD   <= 1'b0;
    end else if (FlushD) begin
      InstrD <= NOP_INSTR;
      ValidD <= 1'b0;
    end else if (!StallD) begin
      if (deliver_c) begin
        InstrD   <= deliver_instr_c;
        PCD      <= pcf_q;
        PCPlus4D <= pcf_q + XLEN'(4);
        ValidD   <= 1'b1;
      end else begin
        InstrD <= NOP_INSTR;
        ValidD <= 1'b0;
      end
    end
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      FetchCount  <= '0;
      BubbleCount <= '0;
    end else if (FlushD || (!StallD && !deliver_c)) begin
      BubbleCount <= BubbleCount + 32'(1);
    end else if (!StallD) begin
      FetchCount <= FetchCount + 32'(1);
    end
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus randomized traffic
// against a behavioural model of the fetch pipeline and a variable-latency memory.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst, StallD, FlushD, PCSrcE, imem_ack, imem_req, ValidD;
  logic [31:0] PCTargetE, imem_addr, imem_rdata, InstrD, PCD, PCPlus4D;
`ifdef FETCH_PERF_EN
  logic [31:0] FetchCount, BubbleCount;
`endif

  fetch_stage dut (
    .clk(clk), .rst(rst), .StallD(StallD), .FlushD(FlushD), .PCSrcE(PCSrcE),
    .PCTargetE(PCTargetE), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .InstrD(InstrD), .PCD(PCD),
    .PCPlus4D(PCPlus4D),
`ifdef FETCH_PERF_EN
    .FetchCount(FetchCount), .BubbleCount(BubbleCount),
`endif
    .ValidD(ValidD)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Behavioural model of the fetch stage
  logic [31:0] m_pc, m_drop_addr, m_skid, m_instr, m_pcd, m_pcp4, m_fc, m_bc;
  logic        m_drop, m_skid_full, m_valid;

  // Memory model
  int          force_lat = 0;
  bit          outstanding = 0;
  int          wait_left = 0;
  logic [31:0] req_addr, req_data;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input logic r, s, f, p, input logic [31:0] t,
                            input logic a, input logic [31:0] d);
    logic [31:0] tgt, dins, dpc;
    logic        dlv;
    tgt  = {t[31:2], 2'b00};
    dlv  = 1'b0;
    dins = 32'h0;
    dpc  = m_pc;
    if (r) begin
      m_pc = 32'h0; m_drop = 1'b0; m_skid_full = 1'b0;
      m_instr = NOP; m_pcd = 32'h0; m_pcp4 = 32'h0; m_valid = 1'b0;
      m_fc = 32'h0; m_bc = 32'h0;
      return;
    end
    if (m_skid_full) begin
      if (p) begin m_skid_full = 1'b0; m_pc = tgt; end
      else if (!s) begin m_skid_full = 1'b0; dlv = 1'b1; dins = m_skid; end
    end else if (m_drop) begin
      if (p) m_pc = tgt;
      if (a) m_drop = 1'b0;
    end else begin
      if (p) begin
        if (!a) begin m_drop = 1'b1; m_drop_addr = m_pc; end
        m_pc = tgt;
      end else if (a) begin
        if (s) begin m_skid_full = 1'b1; m_skid = d; end
        else begin dlv = 1'b1; dins = d; end
      end
    end
    if (dlv) m_pc = m_pc + 32'd4;
    if (f || (!s && !dlv)) begin
      m_instr = NOP; m_valid = 1'b0; m_bc = m_bc + 32'd1;
    end else if (!s) begin
      m_instr = dins; m_pcd = dpc; m_pcp4 = dpc + 32'd4; m_valid = 1'b1;
      m_fc = m_fc + 32'd1;
    end
  endtask

  // One clock: drive controls, answer the memory, step the model, compare.
  task automatic cycle(input logic r, s, f, p, input logic [31:0] t);
    logic a;
    logic [31:0] d;
    @(negedge clk);
    rst = r; StallD = s; FlushD = f; PCSrcE = p; PCTargetE = t;
    #1;
    chk("imem_req", {31'h0, imem_req}, {31'h0, !r && !m_skid_full});
    if (!r && !m_skid_full) chk("imem_addr", imem_addr, m_drop ? m_drop_addr : m_pc);
    a = 1'b0;
    d = $urandom;
    if (imem_req) begin
      if (!outstanding) begin
        outstanding = 1;
        req_addr    = imem_addr;
        req_data    = $urandom;
        if (force_lat >= 0) wait_left = force_lat;
        else wait_left = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 3));
      end else begin
        chk("addr_stable", imem_addr, req_addr);
      end
      a = (wait_left == 0);
      if (a) d = req_data;
    end
    imem_ack = a; imem_rdata = d;
    @(posedge clk);
    model_step(r, s, f, p, t, a, d);
    if (r || a) outstanding = 0;
    else if (outstanding) wait_left--;
    #1;
    chk("InstrD", InstrD, m_instr);
    chk("PCD", PCD, m_pcd);
    chk("PCPlus4D", PCPlus4D, m_pcp4);
    chk("ValidD", {31'h0, ValidD}, {31'h0, m_valid});
`ifdef FETCH_PERF_EN
    chk("FetchCount", FetchCount, m_fc);
    chk("BubbleCount", BubbleCount, m_bc);
`endif
  endtask

  initial begin
    int n;
    rst = 1'b1; StallD = 1'b0; FlushD = 1'b0; PCSrcE = 1'b0; PCTargetE = 32'h0;
    imem_ack = 1'b0; imem_rdata = 32'h0;
    m_pc = 32'h0; m_drop = 1'b0; m_skid_full = 1'b0; m_drop_addr = 32'h0; m_skid = 32'h0;
    m_instr = NOP; m_pcd = 32'h0; m_pcp4 = 32'h0; m_valid = 1'b0; m_fc = 32'h0; m_bc = 32'h0;

    // Reset, then single-cycle memory: back-to-back instructions
    force_lat = 0;
    cycle(1, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0);
    chk("rst_InstrD", InstrD, NOP);
    chk("rst_ValidD", {31'h0, ValidD}, 32'h0);
    chk("rst_PCD", PCD, 32'h0);
    chk("rst_imem_req", {31'h0, imem_req}, 32'h0);
    for (int i = 0; i < 3; i++) begin
      cycle(0, 0, 0, 0, 0);
      chk("seq_PCD", PCD, 32'(i * 4));
      chk("seq_ValidD", {31'h0, ValidD}, 32'h1);
    end

    // Three-cycle memory: bubbles between real instructions
    force_lat = 2;
    for (int i = 0; i < 9; i++) cycle(0, 0, 0, 0, 0);

    // Stall on ack: skid held, request dropped, then released
    force_lat = 0;
    cycle(0, 1, 0, 0, 0);
    cycle(0, 1, 0, 0, 0);
    chk("hold_imem_req", {31'h0, imem_req}, 32'h0);
    cycle(0, 0, 0, 0, 0);
    chk("hold_release_ValidD", {31'h0, ValidD}, 32'h1);

    // Redirect to unaligned target while a slow fetch is pending
    force_lat = 3;
    cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 0, 1, 32'h103);
    n = 0;
    while (m_drop && n < 10) begin
      cycle(0, 0, 0, 0, 0);
      n++;
    end
    chk("drop_done_in_bound", {31'h0, m_drop}, 32'h0);
    chk("redirect_addr", imem_addr, 32'h100);

    // PC wraparound
    force_lat = 0;
    cycle(0, 0, 0, 1, 32'hFFFF_FFFC);
    cycle(0, 0, 0, 0, 0);
    chk("wrap_PCD", PCD, 32'hFFFF_FFFC);
    chk("wrap_PCPlus4D", PCPlus4D, 32'h0);
    chk("wrap_next_addr", imem_addr, 32'h0);

    // Reset in the middle of an abandoned fetch
    force_lat = 3;
    cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 0, 1, 32'h40);
    cycle(1, 0, 0, 0, 0);
    chk("rst_drop_imem_req", {31'h0, imem_req}, 32'h0);
    chk("rst_drop_ValidD", {31'h0, ValidD}, 32'h0);
    chk("rst_drop_PCPlus4D", PCPlus4D, 32'h0);

`ifdef FETCH_PERF_EN
    // Ten acknowledged fetches, three of them flushed
    force_lat = 0;
    cycle(1, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) cycle(0, 0, (i == 2 || i == 5 || i == 8), 0, 0);
    chk("perf_FetchCount", FetchCount, 32'd7);
    chk("perf_BubbleCount", BubbleCount, 32'd3);
`endif

    // Randomized traffic
    force_lat = -1;
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(0, 99) < 1),
            ($urandom_range(0, 99) < 25),
            ($urandom_range(0, 99) < 10),
            ($urandom_range(0, 99) < 10),
            $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
